keypad_scan_ctrl: RTL



---
 rtl/keypad_scan_ctrl_pkg.sv | 28 ++
 rtl/keypad_scan_ctrl_if.sv | 9 +
 rtl/keypad_scan_ctrl_frame_capture.sv | 79 +++++++
 rtl/keypad_scan_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } key_state_t;

    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } frame_class_t;

    localparam logic [3:0] COL_RESET = 4'b0001;
    localparam logic [3:0] COL0      = 4'b0001;
    localparam logic [3:0] COL1      = 4'b0010;
    localparam logic [3:0] COL2      = 4'b0100;
    localparam logic [3:0] COL3      = 4'b1000;

    // Key code = 4*row_index + col_index, which is just the two indices concatenated.
    function automatic logic [3:0] key_code_of(input logic [1:0] row_idx, input logic [1:0] col_idx);
        return {row_idx, col_idx};
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Valid/ready key event channel between the scan controller and its consumers.
interface keypad_scan_ctrl_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;

    modport master (output key_code, output key_valid, input key_ready);
    modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_scan_ctrl_frame_capture.sv
// Row synchroniser, column-scan divider and 16-bit frame capture/classifier.
module keypad_frame_capture
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         scan_en,
    input  logic [3:0]   row,
    output logic [3:0]   col,
    output logic         frame_done,
    output frame_class_t frame_class,
    output logic [3:0]   frame_code
);

    localparam int unsigned DW = $clog2(SCAN_DIV);

    logic [3:0]    row_s1;
    logic [3:0]    row_s2;
    logic [DW-1:0] div;
    logic [1:0]    col_idx;
    logic [15:0]   frame_acc;
    logic [15:0]   frame_now;
    logic          terminal;
    logic [4:0]    ones;

    assign terminal   = scan_en && (div == DW'(SCAN_DIV - 1));
    assign frame_done = terminal && (col_idx == 2'd3);
    assign col        = COL_RESET << col_idx;

    // Two-flop synchroniser for the asynchronous keypad rows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1 <= '0;
            row_s2 <= '0;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
        end
    end

    // Column dwell divider, column rotation and partial-frame storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div       <= '0;
            col_idx   <= '0;
            frame_acc <= '0;
        end else if (scan_en) begin
            if (terminal) begin
                div       <= '0;
                col_idx   <= col_idx + 2'd1;
                frame_acc <= frame_now;
            end else begin
                div <= div + 1'b1;
            end
        end
    end

    // Merge the live column sample into the frame and classify it.
    always_comb begin
        frame_now   = frame_acc;
        ones        = '0;
        frame_code  = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            frame_now[key_code_of(2'(r), col_idx)] = row_s2[r];
        end
        for (int unsigned i = 0; i < 16; i++) begin
            if (frame_now[i]) begin
                ones       = ones + 5'd1;
                frame_code = 4'(i);
            end
        end
        if (ones == 5'd0)      frame_class = NONE;
        else if (ones == 5'd1) frame_class = SINGLE;
        else                   frame_class = MULTI;
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad scan controller: frame debounce FSM and key event handshake register.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                scan_en,
    input  logic [3:0]          row,
    output logic [3:0]          col,
    output logic                key_held,
    output logic                overrun,
    keypad_scan_ctrl_if.master  kif
);

    localparam int unsigned CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_FRAMES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic         frame_done;
    frame_class_t frame_class;
    logic [3:0]   frame_code;

    key_state_t   state, state_n;
    logic [3:0]   cand, cand_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic         emit;

    keypad_frame_capture #(.SCAN_DIV(SCAN_DIV)) u_capture (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_en     (scan_en),
        .row         (row),
        .col         (col),
        .frame_done  (frame_done),
        .frame_class (frame_class),
        .frame_code  (frame_code)
    );

    // Debounce state, candidate code and frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            cnt   <= cnt_n;
        end
    end

    // Frame-end decisions; emit fires on the frame that completes a debounced press.
    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        emit    = 1'b0;
        cnt_inc = cnt + 1'b1;
        if (frame_done) begin
            case (state)
                IDLE: begin
                    if (frame_class == SINGLE) begin
                        cand_n = frame_code;
                        cnt_n  = CNT_ONE;
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_n = PRESSED;
                            emit    = 1'b1;
                        end else begin
                            state_n = PRESS_WAIT;
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (frame_class == SINGLE && frame_code == cand) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            state_n = PRESSED;
                            emit    = 1'b1;
                        end
                    end else if (frame_class == SINGLE) begin
                        cand_n = frame_code;
                        cnt_n  = CNT_ONE;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                PRESSED: begin
                    if (frame_class == NONE) begin
                        cnt_n = CNT_ONE;
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_n = IDLE;
                            cnt_n   = '0;
                        end else begin
                            state_n = RELEASE_WAIT;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (frame_class == NONE) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            state_n = IDLE;
                            cnt_n   = '0;
                        end
                    end else begin
                        state_n = PRESSED;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // A key counts as held from the debounced press until the debounced release.
    always_comb begin
        key_held = (state == PRESSED) || (state == RELEASE_WAIT);
    end

    // Event register: load on emit when free or being drained, otherwise flag overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kif.key_code  <= '0;
            kif.key_valid <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (emit) begin
                if (!kif.key_valid || kif.key_ready) begin
                    kif.key_code  <= cand_n;
                    kif.key_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (kif.key_valid && kif.key_ready) begin
                kif.key_valid <= 1'b0;
            end
        end
    end

endmodule
